// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the hazard unit: the in-flight slot record and fixed select codes.
package hazard_pkg;
  localparam int HZ_ADDR_W_MAX  = 8;  // slot address fields are sized for the widest supported REG_ADDR_W
  localparam int HZ_RDY_W       = 4;
  localparam int FWD_SEL_RF     = 0;
  localparam int ALU_READY_SLOT = 1;

  typedef struct packed {
    logic                     valid;
    logic                     reg_write;
    logic [HZ_ADDR_W_MAX-1:0] rd;
    logic [HZ_RDY_W-1:0]      ready_slot;
    logic [HZ_ADDR_W_MAX-1:0] rs;
    logic [HZ_ADDR_W_MAX-1:0] rt;
    logic                     use_rs;
    logic                     use_rt;
  } hz_slot_t;
endpackage

// File: rtl/pipeline_hazard_unit_hz_match.sv
// Youngest-writer lookup: lowest slot index whose writer destination equals addr_i.
module hz_match #(
  parameter int N  = 2,
  parameter int AW = 5,
  parameter int IW = 2
) (
  input  logic [AW-1:0]        addr_i,
  input  logic                 en_i,
  input  logic [N-1:0]         wr_vld_i,
  input  logic [N-1:0][AW-1:0] wr_rd_i,
  output logic                 hit_o,
  output logic [IW-1:0]        idx_o
);
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (en_i && wr_vld_i[k] && (wr_rd_i[k] == addr_i)) begin
        hit_o = 1'b1;
        idx_o = IW'(k);
      end
    end
  end
endmodule

// File: rtl/pipeline_hazard_unit.sv
// Scoreboard-based stall/forward unit for an EX..WB back-end of configurable depth.
// Optional branch-in-ID stall and IF/ID flush under `HZ_BRANCH_FLUSH_EN.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_is_load_i,
  output logic                  stall_o,
  output logic [SEL_W-1:0]      fwd_a_o,
  output logic [SEL_W-1:0]      fwd_b_o
`ifdef HZ_BRANCH_FLUSH_EN
  ,
  input  logic                  id_is_branch_i,
  input  logic                  id_branch_taken_i,
  output logic                  flush_o
`endif
);
  hz_slot_t [FWD_DEPTH:0] slot_q, slot_d;

  logic [FWD_DEPTH:0]                    wr_vld;
  logic [FWD_DEPTH:0][HZ_ADDR_W_MAX-1:0] wr_rd;
  logic                                  slot_unused;

  always_comb begin
    slot_unused = 1'b0;
    for (int k = 0; k <= FWD_DEPTH; k++) begin
      wr_vld[k] = slot_q[k].valid & slot_q[k].reg_write & (|slot_q[k].rd);
      wr_rd[k]  = slot_q[k].rd;
      if (k > 0)
        slot_unused = slot_unused ^ (^{slot_q[k].rs, slot_q[k].rt, slot_q[k].use_rs, slot_q[k].use_rt});
    end
  end

  logic             id_a_hit, id_b_hit, ex_a_hit, ex_b_hit;
  logic [SEL_W-1:0] id_a_idx, id_b_idx, ex_a_idx, ex_b_idx;

  hz_match #(.N(FWD_DEPTH+1), .AW(HZ_ADDR_W_MAX), .IW(SEL_W)) u_id_a (
    .addr_i(HZ_ADDR_W_MAX'(id_rs_i)), .en_i(id_use_rs_i), .wr_vld_i(wr_vld), .wr_rd_i(wr_rd),
    .hit_o(id_a_hit), .idx_o(id_a_idx));
  hz_match #(.N(FWD_DEPTH+1), .AW(HZ_ADDR_W_MAX), .IW(SEL_W)) u_id_b (
    .addr_i(HZ_ADDR_W_MAX'(id_rt_i)), .en_i(id_use_rt_i), .wr_vld_i(wr_vld), .wr_rd_i(wr_rd),
    .hit_o(id_b_hit), .idx_o(id_b_idx));

  // EX consumer sits in slot 0; its sources are the slots behind it (index 0 here = stage 1).
  hz_match #(.N(FWD_DEPTH), .AW(HZ_ADDR_W_MAX), .IW(SEL_W)) u_ex_a (
    .addr_i(slot_q[0].rs), .en_i(slot_q[0].valid & slot_q[0].use_rs),
    .wr_vld_i(wr_vld[FWD_DEPTH:1]), .wr_rd_i(wr_rd[FWD_DEPTH:1]),
    .hit_o(ex_a_hit), .idx_o(ex_a_idx));
  hz_match #(.N(FWD_DEPTH), .AW(HZ_ADDR_W_MAX), .IW(SEL_W)) u_ex_b (
    .addr_i(slot_q[0].rt), .en_i(slot_q[0].valid & slot_q[0].use_rt),
    .wr_vld_i(wr_vld[FWD_DEPTH:1]), .wr_rd_i(wr_rd[FWD_DEPTH:1]),
    .hit_o(ex_b_hit), .idx_o(ex_b_idx));

  logic a_late, b_late, br_late;

  always_comb begin
    a_late  = id_a_hit && ((int'(id_a_idx) + 1) < int'(slot_q[id_a_idx].ready_slot));
    b_late  = id_b_hit && ((int'(id_b_idx) + 1) < int'(slot_q[id_b_idx].ready_slot));
    br_late = 1'b0;
`ifdef HZ_BRANCH_FLUSH_EN
    // ID compare has no bypass: anything short of WB must drain first.
    br_late = id_is_branch_i &&
              ((id_a_hit && (int'(id_a_idx) < FWD_DEPTH)) ||
               (id_b_hit && (int'(id_b_idx) < FWD_DEPTH)));
`endif
    stall_o = id_valid_i & (a_late | b_late | br_late);
    fwd_a_o = ex_a_hit ? ex_a_idx + SEL_W'(1) : SEL_W'(FWD_SEL_RF);
    fwd_b_o = ex_b_hit ? ex_b_idx + SEL_W'(1) : SEL_W'(FWD_SEL_RF);
  end

`ifdef HZ_BRANCH_FLUSH_EN
  assign flush_o = id_branch_taken_i & id_is_branch_i & ~stall_o;
`endif

  always_comb begin
    slot_d[0] = '0;
    if (id_valid_i && !stall_o) begin
      slot_d[0].valid      = 1'b1;
      slot_d[0].reg_write  = id_reg_write_i;
      slot_d[0].rd         = HZ_ADDR_W_MAX'(id_rd_i);
      slot_d[0].ready_slot = id_is_load_i ? HZ_RDY_W'(1 + LOAD_LAT) : HZ_RDY_W'(ALU_READY_SLOT);
      slot_d[0].rs         = HZ_ADDR_W_MAX'(id_rs_i);
      slot_d[0].rt         = HZ_ADDR_W_MAX'(id_rt_i);
      slot_d[0].use_rs     = id_use_rs_i;
      slot_d[0].use_rt     = id_use_rt_i;
    end
    for (int k = 1; k <= FWD_DEPTH; k++) slot_d[k] = slot_q[k-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) slot_q <= '0;
    else          slot_q <= slot_d;
  end

  // A forwarded source must already hold its result.
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      fwd_a_ready_a: assert (!(ex_a_hit && (int'(fwd_a_o) < int'(slot_q[fwd_a_o].ready_slot))));
      fwd_b_ready_a: assert (!(ex_b_hit && (int'(fwd_b_o) < int'(slot_q[fwd_b_o].ready_slot))));
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed-vector bench: driver queues expected outputs, a negedge monitor checks them.
module tb_pipeline_hazard_unit;
  logic       clk, rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall2, stall3;
  logic [1:0] fa2, fb2, fa3, fb3;
`ifdef HZ_BRANCH_FLUSH_EN
  logic       id_br, id_tk, flush2, flush3;
`endif

  pipeline_hazard_unit u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_is_load_i(id_is_load),
    .stall_o(stall2), .fwd_a_o(fa2), .fwd_b_o(fb2)
`ifdef HZ_BRANCH_FLUSH_EN
    , .id_is_branch_i(id_br), .id_branch_taken_i(id_tk), .flush_o(flush2)
`endif
  );

  pipeline_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_is_load_i(id_is_load),
    .stall_o(stall3), .fwd_a_o(fa3), .fwd_b_o(fb3)
`ifdef HZ_BRANCH_FLUSH_EN
    , .id_is_branch_i(id_br), .id_branch_taken_i(id_tk), .flush_o(flush3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         d3;
    logic       st;
    logic [1:0] fa, fb;
    logic       fl;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic step(input string nm, input bit d3, input bit rst, input bit v,
                      input int rs, input int rt, input bit urs, input bit urt,
                      input int rd, input bit rw, input bit ld,
                      input bit st, input int fa, input int fb,
                      input bit br = 1'b0, input bit tk = 1'b0, input bit fl = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    id_valid     = v;
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_is_load   = ld;
`ifdef HZ_BRANCH_FLUSH_EN
    id_br = br;
    id_tk = tk;
`endif
    e.name = nm; e.d3 = d3; e.st = st; e.fa = 2'(fa); e.fb = 2'(fb); e.fl = fl & br & tk;
    q.push_back(e);
  endtask

  task automatic nop(input string nm, input bit d3, input int fa, input int fb);
    step(nm, d3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb);
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued vector is checked.
  initial begin
    exp_t       e;
    logic       a_st, a_fl;
    logic [1:0] a_fa, a_fb;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e    = q.pop_front();
        a_st = e.d3 ? stall3 : stall2;
        a_fa = e.d3 ? fa3 : fa2;
        a_fb = e.d3 ? fb3 : fb2;
        a_fl = 1'b0;
`ifdef HZ_BRANCH_FLUSH_EN
        a_fl = e.d3 ? flush3 : flush2;
`endif
        tests++;
        if (a_st !== e.st || a_fa !== e.fa || a_fb !== e.fb || a_fl !== e.fl) begin
          fails++;
          $display("FAIL %s (dut%0d): got stall=%0b fa=%0d fb=%0d flush=%0b, want stall=%0b fa=%0d fb=%0d flush=%0b",
                   e.name, e.d3 ? 3 : 2, a_st, a_fa, a_fb, a_fl, e.st, e.fa, e.fb, e.fl);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_rd = '0; id_reg_write = 0; id_is_load = 0;
`ifdef HZ_BRANCH_FLUSH_EN
    id_br = 0; id_tk = 0;
`endif
    repeat (2) @(posedge clk);

    // ALU write then immediate reader: forward from stage 1
    step("alu_wr3",    0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step("alu_rd3",    0, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop ("fwd1_a",     0, 1, 0);
    nop ("fwd1_idle",  0, 0, 0);
    // reader two behind: forward from stage 2
    step("wr3_b",      0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step("filler",     0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rd3_gap",    0, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop ("fwd2_a",     0, 2, 0);
    nop ("fwd2_idle0", 0, 0, 0);
    nop ("fwd2_idle1", 0, 0, 0);
    // load-use on rt: one stall, bubble, then stage 2
    step("ld5",        0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    step("lduse_stall",0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 1, 0, 0);
    step("lduse_go",   0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    nop ("ld_fwd2_b",  0, 0, 2);
    nop ("ld_idle0",   0, 0, 0);
    nop ("ld_idle1",   0, 0, 0);
    // register 0 is never tracked
    step("wr0",        0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("rd0",        0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    nop ("r0_fwd",     0, 0, 0);
    nop ("r0_idle",    0, 0, 0);
    // two writers of $4: youngest wins
    step("wr4_a",      0, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    step("wr4_b",      0, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    step("rd4",        0, 1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop ("youngest_a", 0, 1, 0);
    nop ("y_idle0",    0, 0, 0);
    nop ("y_idle1",    0, 0, 0);
    // both operands on the same writer
    step("wr6",        0, 1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    step("rd66",       0, 1, 1, 6, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    nop ("fwd_ab",     0, 1, 1);
    nop ("ab_idle0",   0, 0, 0);
    nop ("ab_idle1",   0, 0, 0);
    // unused operand never forwards
    step("wr6_b",      0, 1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    step("rd6_rtonly", 0, 1, 1, 6, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    nop ("fwd_b_only", 0, 0, 1);
    nop ("bo_idle0",   0, 0, 0);
    nop ("bo_idle1",   0, 0, 0);
    // invalid ID never stalls
    step("ld5_inv",    0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    step("inv_user",   0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop ("inv_idle0",  0, 0, 0);
    nop ("inv_idle1",  0, 0, 0);
    // back-to-back loads to $5: stall LOAD_LAT cycles on the younger one
    step("ld5_a",      0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    step("ld5_b",      0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    step("b2b_stall",  0, 1, 1, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("b2b_go",     0, 1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop ("b2b_fwd2",   0, 2, 0);
    nop ("b2b_idle",   0, 0, 0);

    // deep instance: FWD_DEPTH=3, LOAD_LAT=2
    step("rst_clear",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("d3_ld7",     1, 1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    step("d3_stall1",  1, 1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("d3_stall2",  1, 1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("d3_go",      1, 1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop ("d3_fwd3",    1, 3, 0);
    nop ("d3_idle0",   1, 0, 0);
    nop ("d3_idle1",   1, 0, 0);
    // reset asserted mid-stall clears at once and forgets the load
    step("d3_ld7_r",   1, 1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    step("d3_pre_rst", 1, 1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("d3_in_rst",  1, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("d3_rst_rel", 1, 1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    nop ("d3_post_rst",1, 0, 0);

`ifdef HZ_BRANCH_FLUSH_EN
    step("br_wr2",     0, 1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    step("br_stall1",  0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    step("br_stall2",  0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    step("br_flush",   0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    nop ("br_idle",    0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
